updown_counter_param: RTL

UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

---
 rtl/updown_counter_pkg.sv | 20 ++
 rtl/updown_next_calc.sv | 115 +++++++++++
 rtl/updown_counter_param.sv | 134 +++++++++++++
 3 files changed

// File: rtl/updown_counter_pkg.sv
// -----------------------------------------------------------------------------
// updown_counter_pkg
// Shared encodings for the parameterised up/down counter.
//   mode_e   : counting mode applied on each enabled cycle
//              (BOUNCE, UP_WRAP, DOWN_WRAP, HOLD)
//   DIR_UP / DIR_DOWN : values carried on the registered direction bit
// -----------------------------------------------------------------------------
package updown_counter_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE    = 2'b00,
        MODE_UP_WRAP   = 2'b01,
        MODE_DOWN_WRAP = 2'b10,
        MODE_HOLD      = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : updown_counter_pkg

// File: rtl/updown_next_calc.sv
// -----------------------------------------------------------------------------
// updown_next_calc
// Purely combinational next-state calculation for one enabled counting step.
// Assumes the caller has already rejected inverted limits (down > upper).
// Ports:
//   count_i     : current count
//   dir_i       : current direction (DIR_UP / DIR_DOWN)
//   mode_i      : counting mode
//   upper_lim_i : inclusive upper bound
//   down_lim_i  : inclusive lower bound
//   step_i      : step size, already guaranteed non-zero
//   count_o     : count after this step
//   dir_o       : direction after this step
//   wrap_o      : wrap or bounce reversal happened on this step
// -----------------------------------------------------------------------------
module updown_next_calc
    import updown_counter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             dir_i,
    input  mode_e            mode_i,
    input  logic [WIDTH-1:0] upper_lim_i,
    input  logic [WIDTH-1:0] down_lim_i,
    input  logic [WIDTH-1:0] step_i,
    output logic [WIDTH-1:0] count_o,
    output logic             dir_o,
    output logic             wrap_o
);

    // One extra bit so count+step and down_lim+step can never overflow and
    // silently wrap the comparison.
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   lo_plus_step;
    logic [WIDTH:0]   hi_ext;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH-1:0] dn_val;

    assign cnt_ext      = {1'b0, count_i};
    assign hi_ext       = {1'b0, upper_lim_i};
    assign up_sum       = cnt_ext + {1'b0, step_i};
    assign lo_plus_step = {1'b0, down_lim_i} + {1'b0, step_i};
    // Only selected when count >= down_lim + step, so it cannot underflow.
    assign dn_val       = count_i - step_i;

    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        count_o = count_i;
        wrap_o  = 1'b0;
        unique case (mode_i)
            MODE_UP_WRAP:   dir_o = DIR_UP;
            MODE_DOWN_WRAP: dir_o = DIR_DOWN;
            default:        dir_o = dir_i;
        endcase

        if (mode_i == MODE_HOLD) begin
            count_o = count_i;
        end else if (down_lim_i == upper_lim_i) begin
            // Degenerate range: pinned to the single legal value, never a wrap.
            count_o = down_lim_i;
        end else if (count_i > upper_lim_i) begin
            // Limits moved underneath the count: snap to the nearest bound.
            count_o = upper_lim_i;
        end else if (count_i < down_lim_i) begin
            count_o = down_lim_i;
        end else begin
            unique case (mode_i)
                MODE_BOUNCE: begin
                    if (dir_i == DIR_UP) begin
                        // Turning on arrival (>=) rather than on overshoot
                        // means the cycle after reaching the limit already
                        // moves away from it: no dwell at the bound.
                        if (up_sum >= hi_ext) begin
                            count_o = upper_lim_i;
                            dir_o   = DIR_DOWN;
                            wrap_o  = 1'b1;
                        end else begin
                            count_o = up_sum[WIDTH-1:0];
                        end
                    end else begin
                        if (cnt_ext <= lo_plus_step) begin
                            count_o = down_lim_i;
                            dir_o   = DIR_UP;
                            wrap_o  = 1'b1;
                        end else begin
                            count_o = dn_val;
                        end
                    end
                end
                MODE_UP_WRAP: begin
                    if (up_sum > hi_ext) begin
                        count_o = down_lim_i;
                        wrap_o  = 1'b1;
                    end else begin
                        count_o = up_sum[WIDTH-1:0];
                    end
                end
                MODE_DOWN_WRAP: begin
                    if (cnt_ext < lo_plus_step) begin
                        count_o = upper_lim_i;
                        wrap_o  = 1'b1;
                    end else begin
                        count_o = dn_val;
                    end
                end
                default: begin
                    count_o = count_i;
                end
            endcase
        end
    end

endmodule : updown_next_calc

// File: rtl/updown_counter_param.sv
// -----------------------------------------------------------------------------
// updown_counter_param
// Bounded up/down counter with bounce, wrap-up, wrap-down and hold modes,
// clamped synchronous load and a limit-error flag.
// Optional feature: define COUNT_STEP_EN to add the 'step' input (step=0 acts
// as 1); otherwise the counter steps by 1.
// Ports:
//   clk        : rising-edge clock
//   rstn       : asynchronous active-low reset
//   en         : count enable, one step per enabled cycle
//   load       : synchronous load of data (clamped), overrides en
//   data       : load value
//   upper_lim  : inclusive upper bound
//   down_lim   : inclusive lower bound
//   mode       : 00 BOUNCE, 01 UP_WRAP, 10 DOWN_WRAP, 11 HOLD
//   step       : step size (COUNT_STEP_EN only)
//   count      : registered count
//   dir        : registered direction, 1 UP / 0 DOWN
//   at_upper   : count == upper_lim (combinational)
//   at_lower   : count == down_lim (combinational)
//   wrap_pulse : registered one-cycle pulse on wrap or bounce reversal
//   lim_err    : registered, high while down_lim > upper_lim
// -----------------------------------------------------------------------------
module updown_counter_param
    import updown_counter_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] upper_lim,
    input  logic [WIDTH-1:0] down_lim,
    input  logic [1:0]       mode,
`ifdef COUNT_STEP_EN
    input  logic [WIDTH-1:0] step,
`endif
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             at_upper,
    output logic             at_lower,
    output logic             wrap_pulse,
    output logic             lim_err
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             lim_err_q;

    logic [WIDTH-1:0] step_eff;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] calc_count;
    logic             calc_dir;
    logic             calc_wrap;
    logic             lim_bad;

`ifdef COUNT_STEP_EN
    // A zero step would stall the counter forever; treat it as one.
    assign step_eff = (step == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : step;
`else
    assign step_eff = {{(WIDTH-1){1'b0}}, 1'b1};
`endif

    assign lim_bad = (down_lim > upper_lim);

    // Loaded values are clamped into the legal window.
    always_comb begin
        load_val = data;
        if (data > upper_lim) begin
            load_val = upper_lim;
        end else if (data < down_lim) begin
            load_val = down_lim;
        end
    end

    updown_next_calc #(
        .WIDTH(WIDTH)
    ) u_next_calc (
        .count_i     (count_q),
        .dir_i       (dir_q),
        .mode_i      (mode_e'(mode)),
        .upper_lim_i (upper_lim),
        .down_lim_i  (down_lim),
        .step_i      (step_eff),
        .count_o     (calc_count),
        .dir_o       (calc_dir),
        .wrap_o      (calc_wrap)
    );

    // Inverted limits freeze everything; the check uses the live limits so
    // counting resumes on the very first edge they become valid again.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        if (!lim_bad) begin
            if (load) begin
                count_d = load_val;
            end else if (en) begin
                count_d = calc_count;
                dir_d   = calc_dir;
                wrap_d  = calc_wrap;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q   <= RST_VAL;
            dir_q     <= DIR_UP;
            wrap_q    <= 1'b0;
            lim_err_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            dir_q     <= dir_d;
            wrap_q    <= wrap_d;
            lim_err_q <= lim_bad;
        end
    end

    assign count      = count_q;
    assign dir        = dir_q;
    assign wrap_pulse = wrap_q;
    assign lim_err    = lim_err_q;
    assign at_upper   = (count_q == upper_lim);
    assign at_lower   = (count_q == down_lim);

endmodule : updown_counter_param
